// File: rtl/univ_shift_reg.sv
// Universal shift register: shift right/left, parallel load, hold, with a
// shift counter that flags each completed WIDTH-bit frame. Serial outputs at
// both ends are taken straight from the register, so the first bit of a
// freshly loaded word is visible immediately.
module univ_shift_reg #(
    parameter int  WIDTH = 8,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             serInR,
    input  logic             serInL,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             serOutR,
    output logic             serOutL,
    output logic [CNTW-1:0]  cnt,
    output logic             full
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Last count value of a frame; the shift that lands here closes the frame.
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    logic [WIDTH-1:0] po_q,   po_d;
    logic [CNTW-1:0]  cnt_q,  cnt_d;
    logic             full_q, full_d;
    logic             shift;

    // Next-state: register datapath, frame counter and the one-cycle full pulse.
    // full defaults low so it can only stay high for the cycle after a frame closes.
    always_comb begin
        po_d   = po_q;
        cnt_d  = cnt_q;
        full_d = 1'b0;
        shift  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    po_d  = {serInR, po_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                MODE_SHL: begin
                    po_d  = {po_q[WIDTH-2:0], serInL};
                    shift = 1'b1;
                end
                MODE_LOAD: begin
                    po_d  = pi;
                    cnt_d = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
        // Both directions count toward the same frame; there is no overflow,
        // the counter just wraps into the next frame.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNTW'(1);
            end
        end
    end

    // State registers; reset wins over enable and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            po_q   <= po_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign po      = po_q;
    assign cnt     = cnt_q;
    assign full    = full_q;
    assign serOutR = po_q[0];
    assign serOutL = po_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: WIDTH=8 for the functional scenarios,
// WIDTH=2 and WIDTH=16 instances for the parameter sweep. All instances share
// control inputs; each scenario starts from a reset.
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst, en, serInR, serInL;
    logic [1:0]  mode;

    logic [7:0]  pi8,  po8;
    logic [3:0]  cnt8;
    logic        full8, sor8, sol8;

    logic [1:0]  pi2,  po2;
    logic [1:0]  cnt2;
    logic        full2, sor2, sol2;

    logic [15:0] pi16, po16;
    logic [4:0]  cnt16;
    logic        full16, sor16, sol16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .serInR(serInR), .serInL(serInL),
        .pi(pi8), .po(po8), .serOutR(sor8), .serOutL(sol8), .cnt(cnt8), .full(full8));

    univ_shift_reg #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .serInR(serInR), .serInL(serInL),
        .pi(pi2), .po(po2), .serOutR(sor2), .serOutL(sol2), .cnt(cnt2), .full(full2));

    univ_shift_reg #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .serInR(serInR), .serInL(serInL),
        .pi(pi16), .po(po16), .serOutR(sor16), .serOutL(sol16), .cnt(cnt16), .full(full16));

    // advance one edge; outputs are sampled 1ns after it, inputs change there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b11;
        pi8 = 8'hFF; pi2 = 2'h3; pi16 = 16'hFFFF;
        tick();
        n_cmp++;
        if ({po8, cnt8, full8, sor8, sol8} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_w8 po/cnt/full/sor/sol got=%h %0d %b %b %b exp=00 0 0 0 0",
                     po8, cnt8, full8, sor8, sol8);
        end
        n_cmp++;
        if ({po2, cnt2, full2, po16, cnt16, full16} !== {2'h0, 2'd0, 1'b0, 16'h0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_w2_w16 got po2=%h cnt2=%0d full2=%b po16=%h cnt16=%0d full16=%b exp all 0",
                     po2, cnt2, full2, po16, cnt16, full16);
        end
        // load then reset with en low: reset must still win
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({po8, cnt8, sor8, sol8} !== {8'hFF, 4'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL load_latency got po=%h cnt=%0d sor=%b sol=%b exp=ff 0 1 1", po8, cnt8, sor8, sol8);
        end
        rst = 1'b1; en = 1'b0;
        tick();
        n_cmp++;
        if ({po8, cnt8, full8} !== {8'h00, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_en_low got po=%h cnt=%0d full=%b exp=00 0 0", po8, cnt8, full8);
        end
        rst = 1'b0; en = 1'b1; mode = 2'b00;
    endtask

    task automatic test_deser_right();
        logic [7:0] bits;
        logic [7:0] exp_po;
        logic [3:0] exp_cnt;
        logic       exp_full;
        bits = 8'h4D;  // serial order bits[0..7] = 1,0,1,1,0,0,1,0
        exp_po = 8'h00;
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            serInR = bits[i];
            tick();
            exp_po   = {bits[i], exp_po[7:1]};
            exp_cnt  = (i == 7) ? 4'd0 : 4'(i + 1);
            exp_full = (i == 7);
            n_cmp++;
            if ({po8, cnt8, full8} !== {exp_po, exp_cnt, exp_full}) begin
                n_err++;
                $display("FAIL deser_right shift%0d got po=%h cnt=%0d full=%b exp=%h %0d %b",
                         i + 1, po8, cnt8, full8, exp_po, exp_cnt, exp_full);
            end
        end
        n_cmp++;
        if (po8 !== 8'h4D) begin
            n_err++;
            $display("FAIL deser_right_word got=%h exp=4d", po8);
        end
        mode = 2'b00;
        tick();
        n_cmp++;
        if ({po8, full8} !== {8'h4D, 1'b0}) begin
            n_err++;
            $display("FAIL deser_right_full_drop got po=%h full=%b exp=4d 0", po8, full8);
        end
    endtask

    task automatic test_serialise_left();
        logic [7:0] tbl [4];
        logic [3:0] sol_exp;
        tbl = '{8'h4A, 8'h94, 8'h28, 8'h50};
        sol_exp = 4'b0101;  // index i: 1,0,1,0
        do_reset();
        mode = 2'b11; pi8 = 8'hA5;
        tick();
        n_cmp++;
        if ({po8, cnt8, full8, sor8} !== {8'hA5, 4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ser_left_load got po=%h cnt=%0d full=%b sor=%b exp=a5 0 0 1", po8, cnt8, full8, sor8);
        end
        mode = 2'b10; serInL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sol8 !== sol_exp[i]) begin
                n_err++;
                $display("FAIL ser_left_sol bit%0d got=%b exp=%b", i, sol8, sol_exp[i]);
            end
            tick();
            n_cmp++;
            if ({po8, cnt8, full8, sor8} !== {tbl[i], 4'(i + 1), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL ser_left_step%0d got po=%h cnt=%0d full=%b sor=%b exp=%h %0d 0 0",
                         i + 1, po8, cnt8, full8, sor8, tbl[i], i + 1);
            end
        end
    endtask

    task automatic test_abort_load();
        logic [7:0] exp_po;
        logic [3:0] exp_cnt;
        logic       exp_full;
        do_reset();
        mode = 2'b01; serInR = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({cnt8, full8} !== {4'(i + 1), 1'b0}) begin
                n_err++;
                $display("FAIL abort_pre shift%0d got cnt=%0d full=%b exp=%0d 0", i + 1, cnt8, full8, i + 1);
            end
        end
        mode = 2'b11; pi8 = 8'h3C;
        tick();
        n_cmp++;
        if ({po8, cnt8, full8} !== {8'h3C, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_load got po=%h cnt=%0d full=%b exp=3c 0 0", po8, cnt8, full8);
        end
        mode = 2'b01; serInR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_po   = 8'h3C >> (i + 1);
            exp_cnt  = (i == 7) ? 4'd0 : 4'(i + 1);
            exp_full = (i == 7);
            n_cmp++;
            if ({po8, cnt8, full8} !== {exp_po, exp_cnt, exp_full}) begin
                n_err++;
                $display("FAIL abort_post shift%0d got po=%h cnt=%0d full=%b exp=%h %0d %b",
                         i + 1, po8, cnt8, full8, exp_po, exp_cnt, exp_full);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] exp_po;
        logic [3:0] exp_cnt;
        logic       exp_full;
        do_reset();
        mode = 2'b01; serInR = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({po8, cnt8, full8} !== {8'hE0, 4'd3, 1'b0}) begin
                n_err++;
                $display("FAIL freeze cycle%0d got po=%h cnt=%0d full=%b exp=e0 3 0", i, po8, cnt8, full8);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_po   = ~(8'hFF >> (i + 4));
            exp_cnt  = (i == 4) ? 4'd0 : 4'(i + 4);
            exp_full = (i == 4);
            n_cmp++;
            if ({po8, cnt8, full8} !== {exp_po, exp_cnt, exp_full}) begin
                n_err++;
                $display("FAIL resume shift%0d got po=%h cnt=%0d full=%b exp=%h %0d %b",
                         i + 4, po8, cnt8, full8, exp_po, exp_cnt, exp_full);
            end
        end
        mode = 2'b00;
        tick();
        n_cmp++;
        if ({po8, full8} !== {8'hFF, 1'b0}) begin
            n_err++;
            $display("FAIL resume_full_drop got po=%h full=%b exp=ff 0", po8, full8);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        mode = 2'b01; serInR = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if ({po8, cnt8} !== {8'hFC, 4'd6}) begin
            n_err++;
            $display("FAIL midrst_pre got po=%h cnt=%0d exp=fc 6", po8, cnt8);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({po8, cnt8, full8} !== {8'h00, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midrst got po=%h cnt=%0d full=%b exp=00 0 0", po8, cnt8, full8);
        end
        // two more shifts would have closed the old frame; they must not
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({cnt8, full8} !== {4'(i + 1), 1'b0}) begin
                n_err++;
                $display("FAIL midrst_post shift%0d got cnt=%0d full=%b exp=%0d 0", i + 1, cnt8, full8, i + 1);
            end
        end
    endtask

    task automatic test_direction_mix();
        do_reset();
        mode = 2'b01; serInR = 1'b1;
        repeat (3) tick();
        mode = 2'b10; serInL = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({cnt8, full8} !== {(i == 4) ? 4'd0 : 4'(i + 4), i == 4}) begin
                n_err++;
                $display("FAIL dirmix shift%0d got cnt=%0d full=%b", i + 4, cnt8, full8);
            end
        end
        n_cmp++;
        if (po8 !== 8'h00) begin
            n_err++;
            $display("FAIL dirmix_po got=%h exp=00", po8);
        end
    endtask

    task automatic test_width2();
        logic [5:0] bits;
        logic [1:0] exp_po;
        bits = 6'b101101;  // serial order bits[0..5] = 1,0,1,1,0,1
        exp_po = 2'b00;
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            serInL = bits[i];
            tick();
            exp_po = {exp_po[0], bits[i]};
            n_cmp++;
            if ({po2, cnt2, full2, sol2, sor2} !== {exp_po, 2'((i + 1) % 2), ((i + 1) % 2) == 0, exp_po[1], exp_po[0]}) begin
                n_err++;
                $display("FAIL w2 shift%0d got po=%h cnt=%0d full=%b sol=%b sor=%b exp po=%h",
                         i + 1, po2, cnt2, full2, sol2, sor2, exp_po);
            end
        end
    endtask

    task automatic test_width16();
        logic [15:0] pat;
        logic [15:0] exp_po;
        pat = 16'hC3A5;
        exp_po = 16'h0000;
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 32; i++) begin
            serInR = pat[i % 16];
            tick();
            exp_po = {pat[i % 16], exp_po[15:1]};
            n_cmp++;
            if ({po16, cnt16, full16, sol16, sor16} !== {exp_po, 5'((i + 1) % 16), ((i + 1) % 16) == 0, exp_po[15], exp_po[0]}) begin
                n_err++;
                $display("FAIL w16 shift%0d got po=%h cnt=%0d full=%b sol=%b sor=%b exp po=%h",
                         i + 1, po16, cnt16, full16, sol16, sor16, exp_po);
            end
            if (i == 15) begin
                n_cmp++;
                if (po16 !== 16'hC3A5) begin
                    n_err++;
                    $display("FAIL w16_word got=%h exp=c3a5", po16);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; serInR = 1'b0; serInL = 1'b0;
        pi8 = '0; pi2 = '0; pi16 = '0;
        #1;
        test_reset();
        test_deser_right();
        test_serialise_left();
        test_abort_load();
        test_enable_freeze();
        test_reset_mid_frame();
        test_direction_mix();
        test_width2();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

endmodule
